// File: rtl/periph_timer.sv
// Memory-mapped timer/status peripheral: reload timer, LED register, optional SYSTICK.
// Optional free-running cycle counter at offset 4 is built when PERIPH_TIMER_SYSTICK_EN is defined.
module periph_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iAddr,
    input  logic        iRead,
    input  logic        iWrite,
    input  logic [31:0] iWriteData,
    output logic [31:0] oReadData,
    output logic        oSel,
    output logic        oIrq,
    output logic [7:0]  oLed
);

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic [31:0] th;
    logic [31:0] tl;
    logic        en;
    logic        irq_en;
    logic        irq_st;
    logic [7:0]  led;
    logic [2:0]  offset;
    logic        wr;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        wr_led;
    logic        wrap;
    logic        wrap_irq;
    logic        unused_lsbs;

    assign oSel        = (iAddr[31:5] == BASE_ADDR[31:5]);
    assign offset      = iAddr[4:2];
    assign unused_lsbs = ^iAddr[1:0];

    assign wr      = oSel & iWrite;
    assign wr_th   = wr & (offset == 3'd0);
    assign wr_tl   = wr & (offset == 3'd1);
    assign wr_tcon = wr & (offset == 3'd2);
    assign wr_led  = wr & (offset == 3'd3);

    // A software write to TL pre-empts both the increment and the overflow event.
    assign wrap     = en & ~wr_tl & (tl == ALL_ONES);
    assign wrap_irq = wrap & irq_en;

`ifdef PERIPH_TIMER_SYSTICK_EN
    logic [31:0] systick;

    always_ff @(posedge clk) begin
        if (reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            th     <= '0;
            tl     <= '0;
            en     <= 1'b0;
            irq_en <= 1'b0;
            irq_st <= 1'b0;
            led    <= '0;
        end else begin
            if (wr_th) begin
                th <= iWriteData;
            end

            // Reload samples the pre-write TH, so a TH write on the wrap edge applies next time.
            if (wr_tl) begin
                tl <= iWriteData;
            end else if (wrap) begin
                tl <= th;
            end else if (en) begin
                tl <= tl + 32'd1;
            end

            if (wr_tcon) begin
                en     <= iWriteData[0];
                irq_en <= iWriteData[1];
            end

            if (wrap_irq) begin
                irq_st <= 1'b1;
            end else if (wr_tcon) begin
                irq_st <= iWriteData[2];
            end

            if (wr_led) begin
                led <= iWriteData[7:0];
            end
        end
    end

    always_comb begin
        oReadData = '0;
        if (oSel && iRead) begin
            case (offset)
                3'd0:    oReadData = th;
                3'd1:    oReadData = tl;
                3'd2:    oReadData = {29'd0, irq_st, irq_en, en};
                3'd3:    oReadData = {24'd0, led};
`ifdef PERIPH_TIMER_SYSTICK_EN
                3'd4:    oReadData = systick;
`endif
                default: oReadData = '0;
            endcase
        end
    end

    assign oIrq = irq_st;
    assign oLed = led;

endmodule

// File: tb/tb_periph_timer.sv
// Directed bench for periph_timer: expected values are queued when stimulus is
// driven and popped when the DUT output is sampled.
module tb_periph_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] iAddr;
    logic        iRead;
    logic        iWrite;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;
    logic        oSel;
    logic        oIrq;
    logic [7:0]  oLed;

    int tests;
    int fails;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    periph_timer #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .iAddr     (iAddr),
        .iRead     (iRead),
        .iWrite    (iWrite),
        .iWriteData(iWriteData),
        .oReadData (oReadData),
        .oSel      (oSel),
        .oIrq      (oIrq),
        .oLed      (oLed)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] exp;
        string       tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        iAddr      = addr;
        iWriteData = data;
        iWrite     = 1'b1;
        step();
        iWrite     = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        iAddr = addr;
        iRead = 1'b1;
        push(tag, exp);
        #1;
        pop_check(oReadData);
        iRead = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_check(obs);
    endtask

    initial begin
        logic [31:0] s0;
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        iAddr      = '0;
        iRead      = 1'b0;
        iWrite     = 1'b0;
        iWriteData = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd($sformatf("reset_off%0d", i), BASE + 32'(i * 4), 32'd0);
        end
        chk("reset_irq", {31'd0, oIrq}, 32'd0);
        chk("reset_led", {24'd0, oLed}, 32'd0);

        // Count up through overflow with interrupts enabled.
        wr(BASE + 0, 32'hFFFF_FFF0);
        wr(BASE + 4, 32'hFFFF_FFFD);
        wr(BASE + 8, 32'd3);
        rd("tl_start", BASE + 4, 32'hFFFF_FFFD);
        step();
        rd("tl_inc1", BASE + 4, 32'hFFFF_FFFE);
        step();
        rd("tl_inc2", BASE + 4, 32'hFFFF_FFFF);
        chk("irq_before_ovf", {31'd0, oIrq}, 32'd0);
        step();
        rd("tl_reload", BASE + 4, 32'hFFFF_FFF0);
        chk("irq_at_ovf", {31'd0, oIrq}, 32'd1);
        rd("tcon_status", BASE + 8, 32'd7);

        // Clear status; counting continues.
        wr(BASE + 8, 32'd3);
        chk("irq_cleared", {31'd0, oIrq}, 32'd0);
        rd("tl_after_clear", BASE + 4, 32'hFFFF_FFF1);
        step();
        rd("tl_continue", BASE + 4, 32'hFFFF_FFF2);

        // Clear on the overflow edge: set wins.
        wr(BASE + 4, 32'hFFFF_FFFE);
        wr(BASE + 8, 32'd3);
        rd("tl_pre_ovf", BASE + 4, 32'hFFFF_FFFF);
        wr(BASE + 8, 32'd3);
        chk("irq_clear_vs_set", {31'd0, oIrq}, 32'd1);
        rd("tl_clear_ovf", BASE + 4, 32'hFFFF_FFF0);

        // Interrupt disabled: reload still happens, no status.
        wr(BASE + 8, 32'd1);
        chk("irq_off", {31'd0, oIrq}, 32'd0);
        wr(BASE + 4, 32'hFFFF_FFFF);
        step();
        rd("tl_reload_noirq", BASE + 4, 32'hFFFF_FFF0);
        chk("irq_stays_low", {31'd0, oIrq}, 32'd0);

        // TL write on the overflow edge wins.
        wr(BASE + 4, 32'hFFFF_FFFF);
        wr(BASE + 4, 32'd5);
        rd("tl_write_wins", BASE + 4, 32'd5);
        step();
        rd("tl_after_write", BASE + 4, 32'd6);

        // TH write on the overflow edge: reload uses old TH.
        wr(BASE + 4, 32'hFFFF_FFFF);
        wr(BASE + 0, 32'h0000_1234);
        rd("tl_old_th", BASE + 4, 32'hFFFF_FFF0);
        rd("th_new", BASE + 0, 32'h0000_1234);

        // Disable holds TL; upper TCON bits ignored; bit2 self-test path.
        wr(BASE + 8, 32'hFFFF_FFF8);
        rd("tcon_upper_ignored", BASE + 8, 32'd0);
        rd("tl_hold_a", BASE + 4, 32'hFFFF_FFF1);
        step();
        rd("tl_hold_b", BASE + 4, 32'hFFFF_FFF1);
        wr(BASE + 8, 32'd4);
        chk("irq_selftest", {31'd0, oIrq}, 32'd1);
        rd("tcon_selftest", BASE + 8, 32'd4);
        wr(BASE + 8, 32'd0);
        chk("irq_selftest_clr", {31'd0, oIrq}, 32'd0);

        // Simultaneous read and write: read shows pre-write value.
        iAddr      = BASE + 12;
        iWriteData = 32'h0000_01A5;
        iWrite     = 1'b1;
        iRead      = 1'b1;
        push("rw_prewrite", 32'd0);
        #1;
        pop_check(oReadData);
        step();
        iWrite = 1'b0;
        iRead  = 1'b0;
        chk("led_out", {24'd0, oLed}, 32'h0000_00A5);
        rd("led_read", BASE + 12, 32'h0000_00A5);

        // Outside the window and unused offsets.
        iAddr = 32'h4000_0020;
        iRead = 1'b1;
        #1;
        chk("outside_sel", {31'd0, oSel}, 32'd0);
        chk("outside_rdata", oReadData, 32'd0);
        iRead = 1'b0;
        wr(32'h4000_0020, 32'h0000_0055);
        wr(BASE + 20, 32'h0000_0077);
        chk("outside_led", {24'd0, oLed}, 32'h0000_00A5);
        rd("th_untouched", BASE + 0, 32'h0000_1234);
        rd("off5_zero", BASE + 20, 32'd0);
        rd("byte_offset_ignored", BASE + 13, 32'h0000_00A5);

        // Offset 4.
`ifdef PERIPH_TIMER_SYSTICK_EN
        iAddr = BASE + 16;
        iRead = 1'b1;
        #1;
        s0    = oReadData;
        iRead = 1'b0;
        repeat (10) step();
        rd("systick_delta", BASE + 16, s0 + 32'd10);
`else
        s0 = 32'd0;
        rd("systick_absent", BASE + 16, s0);
`endif

        // Reset mid-count with a concurrent write.
        wr(BASE + 8, 32'd7);
        iAddr      = BASE + 4;
        iWriteData = 32'h0000_BEEF;
        iWrite     = 1'b1;
        reset      = 1'b1;
        step();
        reset  = 1'b0;
        iWrite = 1'b0;
        rd("rst_th", BASE + 0, 32'd0);
        rd("rst_tl", BASE + 4, 32'd0);
        rd("rst_tcon", BASE + 8, 32'd0);
        rd("rst_led", BASE + 12, 32'd0);
        rd("rst_off4", BASE + 16, 32'd0);
        chk("rst_irq", {31'd0, oIrq}, 32'd0);
        chk("rst_ledout", {24'd0, oLed}, 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
